fp_sqrt_arb: RTL

- Round-robin scheduler that shares one fp_sqrt pipeline among NREQ requesters.
- Per-requester valid/ready inputs; one tagged response channel with valid/ready.
- Drives the pipeline's src0, vldin and en. Tracks request tags in a shadow shift register that matches the pipeline latency.
- Stalls the whole pipeline (en=0) when the response consumer back-pressures.

---
 rtl/fp_sqrt_arb.sv | 120 ++++++++++++
 1 files changed

// File: rtl/fp_sqrt_arb.sv
// fp_sqrt_arb: round-robin sharing of one fp_sqrt pipeline
// among NREQ requesters, with a tag shadow matching pipe depth.
module fp_sqrt_arb #(
  parameter int NREQ    = 4,
  parameter int TAGW    = 2,
  parameter int LATENCY = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_vld,
  input  logic [32*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   req_rdy,
  output logic              rsp_vld,
  input  logic              rsp_rdy,
  output logic [TAGW-1:0]   rsp_tag,
  output logic [31:0]       rsp_data,
  output logic [31:0]       sq_src0,
  output logic              sq_vldin,
  output logic              sq_en,
  input  logic [31:0]       sq_out,
  input  logic              sq_vldout,
  output logic [3:0]        inflight,
  output logic              tag_err
);

  typedef struct packed {
    logic            v;
    logic [TAGW-1:0] tag;
  } ent_t;

  ent_t            sh [LATENCY];
  logic [TAGW-1:0] rr_ptr;
  logic [TAGW-1:0] winner;
  logic            found;
  logic            grant;
  logic            deliver;

  // freeze the whole pipe while a finished result waits
  assign sq_en = !(sq_vldout && !rsp_rdy);

  // first valid requester after the last winner
  always_comb begin
    int idx;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req_vld[idx]) begin
        found  = 1'b1;
        winner = TAGW'(idx);
      end
    end
  end

  // reset masks the grant so nothing is accepted while held
  assign grant = found && sq_en && rst_n;

  // one-hot accept toward the winner
  always_comb begin
    req_rdy = '0;
    if (grant) req_rdy[winner] = 1'b1;
  end

  assign sq_vldin = |(req_vld & req_rdy);

  // operand mux, zero when idle
  always_comb begin
    sq_src0 = '0;
    if (grant) sq_src0 = req_data[32*int'(winner) +: 32];
  end

  // pointer moves only when something was granted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= TAGW'(NREQ - 1);
    end else if (sq_vldin) begin
      rr_ptr <= winner;
    end
  end

  // tag shadow shifts in lockstep with the pipeline enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LATENCY; i++) sh[i] <= '0;
    end else if (sq_en) begin
      sh[0] <= '{v: sq_vldin, tag: winner};
      for (int i = 1; i < LATENCY; i++) sh[i] <= sh[i-1];
    end
  end

  assign rsp_vld  = sq_vldout;
  assign rsp_data = sq_out;
  assign rsp_tag  = sh[LATENCY-1].tag;
  assign deliver  = sq_vldout && rsp_rdy;

  // accepted-but-undelivered count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= '0;
    end else begin
      unique case ({sq_vldin, deliver})
        2'b10:   inflight <= inflight + 4'd1;
        2'b01:   inflight <= inflight - 4'd1;
        default: inflight <= inflight;
      endcase
    end
  end

  // sticky flag when shadow and pipe disagree on validity
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_err <= 1'b0;
    end else if (sh[LATENCY-1].v != sq_vldout) begin
      tag_err <= 1'b1;
    end
  end

endmodule
